// File: rtl/word_serializer.sv
// Parallel-to-serial converter: a 2-entry input FIFO feeds a shift register that
// emits one bit per ready/valid transfer, with ser_last marking the final bit of each word.
//
// state | meaning
// IDLE  | no word in the shifter; loads the FIFO head as soon as one is buffered
// SHIFT | presenting shift register bits; counter tracks the current bit index
module word_serializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last,
    input  logic             ser_ready,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] fifo_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic [WIDTH-1:0] sr_q;
    logic [CW-1:0]    cnt_q;
    logic             live_q;

    logic push;
    logic pop;
    logic xfer;
    logic word_end;

    // live_q keeps in_ready low until the first edge after reset release
    assign in_ready  = live_q && (count_q != 2'd2);
    assign ser_valid = (state_q == SHIFT);
    assign ser_last  = (state_q == SHIFT) && (cnt_q == CW'(WIDTH - 1));
    assign ser_out   = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];
    assign busy      = (state_q == SHIFT) || (count_q != 2'd0);

    assign push     = in_valid && in_ready;
    assign xfer     = ser_valid && ser_ready;
    assign word_end = xfer && ser_last;
    assign pop      = (count_q != 2'd0) && ((state_q == IDLE) || word_end);

    always_comb begin
        count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
            sr_q      <= '0;
            cnt_q     <= '0;
            live_q    <= 1'b0;
        end else begin
            live_q  <= 1'b1;
            count_q <= count_d;
            if (push) begin
                fifo_q[wr_ptr_q] <= in_data;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end

            case (state_q)
                IDLE: begin
                    if (pop) begin
                        sr_q    <= fifo_q[rd_ptr_q];
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (word_end) begin
                        // Chain straight into the next buffered word with no idle bubble
                        cnt_q <= '0;
                        if (pop) begin
                            sr_q <= fifo_q[rd_ptr_q];
                        end else begin
                            sr_q    <= '0;
                            state_q <= IDLE;
                        end
                    end else if (xfer) begin
                        sr_q  <= MSB_FIRST ? {sr_q[WIDTH-2:0], 1'b0}
                                           : {1'b0, sr_q[WIDTH-1:1]};
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_word_serializer.sv
// Self-checking bench for word_serializer: directed scenarios plus a randomized
// stream checked against a queue of expected (bit, last) pairs.
module tb_word_serializer;

    logic       clk;
    logic       reset;
    logic [3:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       ser_out;
    logic       ser_valid;
    logic       ser_last;
    logic       ser_ready;
    logic       busy;

    logic [3:0] m_in_data;
    logic       m_in_valid;
    logic       m_in_ready;
    logic       m_ser_out;
    logic       m_ser_valid;
    logic       m_ser_last;
    logic       m_ser_ready;
    logic       m_busy;

    int checks = 0;
    int errors = 0;

    word_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .ser_out(ser_out), .ser_valid(ser_valid),
        .ser_last(ser_last), .ser_ready(ser_ready), .busy(busy)
    );

    word_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset(reset), .in_data(m_in_data), .in_valid(m_in_valid),
        .in_ready(m_in_ready), .ser_out(m_ser_out), .ser_valid(m_ser_valid),
        .ser_last(m_ser_last), .ser_ready(m_ser_ready), .busy(m_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit i (in transmission order) of a 4-bit word
    function automatic logic exp_bit(input logic [3:0] w, input int i, input bit msb);
        return msb ? w[3 - i] : w[i];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b1; in_data = 4'hF; ser_ready = 1'b1;
        m_in_valid = 1'b0; m_in_data = 4'h0; m_ser_ready = 1'b1;
        #1;
        repeat (2) tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
        checks++; if (ser_valid !== 1'b0) begin errors++; $display("FAIL rst_ser_valid got %b exp 0", ser_valid); end
        checks++; if (ser_last !== 1'b0) begin errors++; $display("FAIL rst_ser_last got %b exp 0", ser_last); end
        checks++; if (ser_out !== 1'b0) begin errors++; $display("FAIL rst_ser_out got %b exp 0", ser_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        reset = 1'b1; in_valid = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rel_in_ready_early got %b exp 0", in_ready); end
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rel_in_ready got %b exp 1", in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rel_busy got %b exp 0", busy); end
    endtask

    task automatic test_single();
        logic [3:0] w;
        w = 4'b1010;
        ser_ready = 1'b1; in_data = w; in_valid = 1'b1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready got %b exp 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (ser_valid !== 1'b0) begin errors++; $display("FAIL single_latency got %b exp 0", ser_valid); end
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++; if (ser_valid !== 1'b1) begin errors++; $display("FAIL single_valid[%0d] got %b exp 1", i, ser_valid); end
            checks++; if (ser_out !== exp_bit(w, i, 1'b0)) begin errors++; $display("FAIL single_bit[%0d] got %b exp %b", i, ser_out, exp_bit(w, i, 1'b0)); end
            checks++; if (ser_last !== (i == 3)) begin errors++; $display("FAIL single_last[%0d] got %b exp %b", i, ser_last, (i == 3)); end
            tick();
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b exp 0", busy); end
        checks++; if (ser_valid !== 1'b0) begin errors++; $display("FAIL single_valid_end got %b exp 0", ser_valid); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] w [2];
        w[0] = 4'b1100; w[1] = 4'b0011;
        ser_ready = 1'b1;
        in_data = w[0]; in_valid = 1'b1;
        tick();
        in_data = w[1];
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got %b exp 1", in_ready); end
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            checks++; if (ser_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d] got %b exp 1", k, ser_valid); end
            checks++; if (ser_out !== exp_bit(w[k / 4], k % 4, 1'b0)) begin errors++; $display("FAIL b2b_bit[%0d] got %b exp %b", k, ser_out, exp_bit(w[k / 4], k % 4, 1'b0)); end
            checks++; if (ser_last !== ((k % 4) == 3)) begin errors++; $display("FAIL b2b_last[%0d] got %b exp %b", k, ser_last, ((k % 4) == 3)); end
            tick();
        end
        checks++; if (ser_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_end got %b exp 0", ser_valid); end
    endtask

    task automatic test_backpressure();
        logic [3:0] w;
        w = 4'b1001;
        ser_ready = 1'b0; in_data = w; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        for (int s = 0; s < 3; s++) begin
            checks++; if (ser_valid !== 1'b1) begin errors++; $display("FAIL bp_stall_valid[%0d] got %b exp 1", s, ser_valid); end
            checks++; if (ser_out !== 1'b1) begin errors++; $display("FAIL bp_stall_bit[%0d] got %b exp 1", s, ser_out); end
            checks++; if (ser_last !== 1'b0) begin errors++; $display("FAIL bp_stall_last[%0d] got %b exp 0", s, ser_last); end
            tick();
        end
        ser_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (ser_out !== exp_bit(w, i, 1'b0)) begin errors++; $display("FAIL bp_bit[%0d] got %b exp %b", i, ser_out, exp_bit(w, i, 1'b0)); end
            checks++; if (ser_last !== (i == 3)) begin errors++; $display("FAIL bp_last[%0d] got %b exp %b", i, ser_last, (i == 3)); end
            tick();
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_busy_end got %b exp 0", busy); end
    endtask

    task automatic test_full();
        logic [3:0] w [4];
        logic [1:0] q [$];
        logic [1:0] e;
        int xfers;
        int acc_at;
        bit acc;
        for (int i = 0; i < 4; i++) w[i] = 4'($urandom);
        ser_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_data = w[i]; in_valid = 1'b1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_in_ready[%0d] got %b exp 1", i, in_ready); end
            for (int b = 0; b < 4; b++) q.push_back({(b == 3) ? 1'b1 : 1'b0, exp_bit(w[i], b, 1'b0)});
            tick();
        end
        in_data = w[3]; in_valid = 1'b1;
        for (int s = 0; s < 3; s++) begin
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_blocked[%0d] got %b exp 0", s, in_ready); end
            tick();
        end
        ser_ready = 1'b1;
        xfers = 0; acc_at = -1;
        for (int c = 0; c < 60 && (q.size() != 0 || busy || in_valid); c++) begin
            acc = in_valid && in_ready;
            if (ser_valid && ser_ready) begin
                if (q.size() == 0) begin
                    checks++; errors++; $display("FAIL full_extra_bit got %b exp none", ser_out);
                end else begin
                    e = q.pop_front();
                    checks++; if (ser_out !== e[0]) begin errors++; $display("FAIL full_bit[%0d] got %b exp %b", xfers, ser_out, e[0]); end
                    checks++; if (ser_last !== e[1]) begin errors++; $display("FAIL full_last[%0d] got %b exp %b", xfers, ser_last, e[1]); end
                end
            end
            if (acc) begin
                acc_at = xfers;
                for (int b = 0; b < 4; b++) q.push_back({(b == 3) ? 1'b1 : 1'b0, exp_bit(w[3], b, 1'b0)});
            end
            if (ser_valid && ser_ready) xfers++;
            tick();
            if (acc) in_valid = 1'b0;
        end
        checks++; if (acc_at !== 4) begin errors++; $display("FAIL full_accept_point got %0d exp 4", acc_at); end
        checks++; if (q.size() !== 0 || busy !== 1'b0) begin errors++; $display("FAIL full_drain got left=%0d busy=%b exp left=0 busy=0", q.size(), busy); end
    endtask

    task automatic test_reset_mid_word();
        logic [3:0] w;
        ser_ready = 1'b1; in_data = 4'b0110; in_valid = 1'b1;
        tick();
        in_data = 4'b0101;
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        #2 reset = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_in_ready got %b exp 0", in_ready); end
        checks++; if (ser_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_ser_valid got %b exp 0", ser_valid); end
        checks++; if (ser_last !== 1'b0) begin errors++; $display("FAIL mid_rst_ser_last got %b exp 0", ser_last); end
        checks++; if (ser_out !== 1'b0) begin errors++; $display("FAIL mid_rst_ser_out got %b exp 0", ser_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b exp 0", busy); end
        tick();
        reset = 1'b1;
        tick();
        checks++; if (busy !== 1'b0 || ser_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_resume got busy=%b valid=%b exp 0 0", busy, ser_valid); end
        w = 4'b1111;
        in_data = w; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++; if (ser_valid !== 1'b1 || ser_out !== 1'b1) begin errors++; $display("FAIL mid_rst_new[%0d] got valid=%b bit=%b exp 1 1", i, ser_valid, ser_out); end
            checks++; if (ser_last !== (i == 3)) begin errors++; $display("FAIL mid_rst_last[%0d] got %b exp %b", i, ser_last, (i == 3)); end
            tick();
        end
        checks++; if (ser_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_rst_stale got valid=%b busy=%b exp 0 0", ser_valid, busy); end
    endtask

    task automatic test_msb_first();
        logic [3:0] w;
        w = 4'b1000;
        m_ser_ready = 1'b1; m_in_data = w; m_in_valid = 1'b1;
        tick();
        m_in_valid = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++; if (m_ser_valid !== 1'b1) begin errors++; $display("FAIL msb_valid[%0d] got %b exp 1", i, m_ser_valid); end
            checks++; if (m_ser_out !== exp_bit(w, i, 1'b1)) begin errors++; $display("FAIL msb_bit[%0d] got %b exp %b", i, m_ser_out, exp_bit(w, i, 1'b1)); end
            checks++; if (m_ser_last !== (i == 3)) begin errors++; $display("FAIL msb_last[%0d] got %b exp %b", i, m_ser_last, (i == 3)); end
            tick();
        end
        checks++; if (m_busy !== 1'b0) begin errors++; $display("FAIL msb_busy_end got %b exp 0", m_busy); end
    endtask

    task automatic test_random();
        logic [1:0] q [$];
        logic [1:0] e;
        bit draining;
        for (int c = 0; c < 500; c++) begin
            draining = (c >= 300);
            if (draining && q.size() == 0 && !busy) break;
            in_valid  = draining ? 1'b0 : 1'($urandom_range(0, 1));
            in_data   = 4'($urandom);
            ser_ready = draining ? 1'b1 : ($urandom_range(0, 9) < 7);
            checks++; if (busy !== (q.size() != 0)) begin errors++; $display("FAIL rnd_busy[%0d] got %b exp %b", c, busy, (q.size() != 0)); end
            if (ser_valid && ser_ready) begin
                if (q.size() == 0) begin
                    checks++; errors++; $display("FAIL rnd_extra_bit[%0d] got %b exp none", c, ser_out);
                end else begin
                    e = q.pop_front();
                    checks++; if (ser_out !== e[0]) begin errors++; $display("FAIL rnd_bit[%0d] got %b exp %b", c, ser_out, e[0]); end
                    checks++; if (ser_last !== e[1]) begin errors++; $display("FAIL rnd_last[%0d] got %b exp %b", c, ser_last, e[1]); end
                end
            end
            if (in_valid && in_ready) begin
                for (int b = 0; b < 4; b++) q.push_back({(b == 3) ? 1'b1 : 1'b0, exp_bit(in_data, b, 1'b0)});
            end
            tick();
        end
        in_valid = 1'b0;
        checks++; if (q.size() !== 0 || busy !== 1'b0) begin errors++; $display("FAIL rnd_drain got left=%0d busy=%b exp left=0 busy=0", q.size(), busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_full();
        test_reset_mid_word();
        test_msb_first();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
